// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, loads IF/ID, and applies stalls and redirects.
// Fetch freezes on the halt word and resumes only when EX redirects.
module fetch_ctrl #(
  parameter int          ADDR_W    = 8,
  parameter int          RESET_PC  = 1,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ifid_instr;
  logic [ADDR_W-1:0] r_ifid_pc;
  logic              r_ifid_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic w_halt_hit;
  logic w_cnt_sat;

  assign w_halt_hit = (imem_data == HALT_WORD);
  assign w_cnt_sat  = (r_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_pc         <= ADDR_W'(RESET_PC);
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
      r_cnt        <= '0;
    end else if (redirect) begin
      // Honoured in HALT too: the halt word may have been a wrong-path fetch.
      r_state      <= S_RUN;
      r_pc         <= redirect_pc;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (r_state == S_RUN && !stall) begin
      if (w_halt_hit) begin
        r_state      <= S_HALT;
        r_ifid_instr <= '0;
        r_ifid_pc    <= '0;
        r_ifid_valid <= 1'b0;
      end else begin
        r_ifid_instr <= imem_data;
        r_ifid_pc    <= r_pc;
        r_ifid_valid <= 1'b1;
        r_pc         <= r_pc + ADDR_W'(1);
        if (!w_cnt_sat) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign imem_addr  = r_pc;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc    = r_ifid_pc;
  assign ifid_valid = r_ifid_valid;
  assign halted     = (r_state == S_HALT);
  assign fetch_cnt  = r_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle comparison against a behavioural model plus
// directed literal checks for reset, sequencing, stall, redirect, halt and wrap/saturate.
module tb_fetch_ctrl;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [31:0]       ifid_instr;
  logic [ADDR_W-1:0] ifid_pc;
  logic              ifid_valid;
  logic              halted;
  logic [CNT_W-1:0]  fetch_cnt;

  logic [31:0] mem [256];
  assign imem_data = mem[imem_addr];

  fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(1), .HALT_WORD(HALT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, rules applied in priority order.
  int m_pc, m_ipc, m_cnt;
  logic [31:0] m_instr;
  bit m_valid, m_halt;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 1; m_halt = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_cnt = 0;
    end else if (redirect) begin
      m_pc = int'(redirect_pc); m_halt = 0; m_instr = 0; m_ipc = 0; m_valid = 0;
    end else if (!m_halt && !stall) begin
      if (mem[m_pc] == HALT) begin
        m_halt = 1; m_instr = 0; m_ipc = 0; m_valid = 0;
      end else begin
        m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1;
        m_pc  = (m_pc + 1) % (1 << ADDR_W);
        m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.imem_addr",  32'(imem_addr),  32'(m_pc));
      chk("m.ifid_instr", ifid_instr,      m_instr);
      chk("m.ifid_pc",    32'(ifid_pc),    32'(m_ipc));
      chk("m.ifid_valid", 32'(ifid_valid), 32'(m_valid));
      chk("m.halted",     32'(halted),     32'(m_halt));
      chk("m.fetch_cnt",  32'(fetch_cnt),  32'(m_cnt));
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h2400_0000 | 32'(i);
    mem[1] = 32'h2001_0009;
    mem[2] = 32'h0000_1020;
    mem[3] = 32'h0000_2020;
    mem[8'h13] = HALT;

    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;

    // T1: run to pc=7, then reset mid-run
    tick(6);
    chk("t1.pre_pc", 32'(imem_addr), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1.addr",   32'(imem_addr),  32'd1);
    chk("t1.valid",  32'(ifid_valid), 32'd0);
    chk("t1.halted", 32'(halted),     32'd0);
    chk("t1.cnt",    32'(fetch_cnt),  32'd0);

    // T2: sequential fetch
    tick();
    chk("t2.i1", ifid_instr, 32'h2001_0009);
    chk("t2.p1", 32'(ifid_pc), 32'd1);
    chk("t2.v1", 32'(ifid_valid), 32'd1);
    tick();
    chk("t2.i2", ifid_instr, 32'h0000_1020);
    chk("t2.p2", 32'(ifid_pc), 32'd2);
    tick();
    chk("t2.i3", ifid_instr, 32'h0000_2020);
    chk("t2.p3", 32'(ifid_pc), 32'd3);
    chk("t2.cnt", 32'(fetch_cnt), 32'd3);

    // T3: two stall cycles at pc=4
    stall = 1'b1;
    tick();
    chk("t3.addr_a", 32'(imem_addr), 32'd4);
    tick();
    chk("t3.addr_b", 32'(imem_addr), 32'd4);
    chk("t3.ipc",    32'(ifid_pc),   32'd3);
    chk("t3.instr",  ifid_instr,     32'h0000_2020);
    chk("t3.cnt",    32'(fetch_cnt), 32'd3);
    stall = 1'b0;
    tick();
    chk("t3.rel_ipc",  32'(ifid_pc),   32'd4);
    chk("t3.rel_addr", 32'(imem_addr), 32'd5);

    // T4: redirect beats stall
    redirect = 1'b1; stall = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("t4.addr",  32'(imem_addr),  32'h10);
    chk("t4.valid", 32'(ifid_valid), 32'd0);
    chk("t4.cnt",   32'(fetch_cnt),  32'd4);

    // T5: fetch 0x10..0x12, stall over the halt word, then halt
    tick(3);
    chk("t5.pre_addr", 32'(imem_addr), 32'h13);
    chk("t5.pre_cnt",  32'(fetch_cnt), 32'd7);
    stall = 1'b1;
    tick();
    chk("t5.stall_nohalt", 32'(halted), 32'd0);
    stall = 1'b0;
    tick();
    chk("t5.halted", 32'(halted),     32'd1);
    chk("t5.valid",  32'(ifid_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      tick();
      chk("t5.hold_addr",  32'(imem_addr),  32'h13);
      chk("t5.hold_valid", 32'(ifid_valid), 32'd0);
      chk("t5.hold_halt",  32'(halted),     32'd1);
    end
    stall = 1'b0;
    redirect = 1'b1; redirect_pc = 8'h02;
    tick();
    redirect = 1'b0;
    chk("t5.unhalt", 32'(halted),    32'd0);
    chk("t5.raddr",  32'(imem_addr), 32'd2);
    tick();
    chk("t5.resume_i", ifid_instr,     32'h0000_1020);
    chk("t5.resume_p", 32'(ifid_pc),   32'd2);
    chk("t5.resume_c", 32'(fetch_cnt), 32'd8);

    // T6: PC wrap and counter saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    tick();
    chk("t6.wrap_ipc",  32'(ifid_pc),   32'hFF);
    chk("t6.wrap_addr", 32'(imem_addr), 32'h00);
    chk("t6.cnt1",      32'(fetch_cnt), 32'd1);
    redirect = 1'b1; redirect_pc = 8'h30;
    tick();
    redirect = 1'b0;
    tick(20);
    chk("t6.sat",     32'(fetch_cnt), 32'd15);
    chk("t6.lastipc", 32'(ifid_pc),   32'h43);

    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
